// File: rtl/cmd_bridge_pkg.sv
// Shared types and constants for the UART-to-register command bridge.
package cmd_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        WR_ISSUE = 3'd2,
        RD_REQ   = 3'd3,
        RD_WAIT  = 3'd4,
        TX       = 3'd5
    } state_t;

    localparam int CMD_WR_BIT = 7;

endpackage

// File: rtl/cmd_bridge_timer.sv
// Stall watchdog: counts enabled cycles since the last clear and flags expiry.
module cmd_timer #(
    parameter int TIMEOUT_CYC = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    logic [CW-1:0] count_r;

    // Cycle counter; saturates so it can never wrap back below the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != LIMIT)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry is seen in the cycle before the TIMEOUT_CYC-th edge, so the abort lands on that edge.
    assign expired = (TIMEOUT_CYC > 0) && en && (count_r == LIMIT);

endmodule

// File: rtl/cmd_bridge.sv
// Command bridge: decodes a UART command byte, performs one register write or read,
// and streams read data back LSB first under transmitter back-pressure.
module cmd_bridge
    import cmd_bridge_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_BYTES  = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic                    reg_wr,
    output logic                    reg_rd,
    output logic [ADDR_W-1:0]       reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    input  logic [8*DATA_BYTES-1:0] reg_rdata,
    input  logic                    reg_rd_valid,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int DW    = 8 * DATA_BYTES;
    localparam int CNT_W = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BYTES - 1);

    state_t            state_r, state_next;
    logic [CNT_W-1:0]  cnt_r, cnt_next;
    logic [DW-1:0]     data_r, data_next;
    logic [ADDR_W-1:0] addr_r, addr_next;
    logic              timeout_s, rx_take_s, expired_s, timer_clr_s, timer_en_s;
    logic [7:0]        tx_byte_s;

    logic              busy_r, reg_wr_r, reg_rd_r, tx_valid_r, err_r;
    logic [7:0]        tx_data_r;
    logic [DW-1:0]     reg_wdata_r;
    logic [ADDR_W-1:0] reg_addr_r;

    // Next-state, byte counter and data path decisions.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        data_next  = data_r;
        addr_next  = addr_r;
        timeout_s  = 1'b0;
        rx_take_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    addr_next  = rx_data[ADDR_W-1:0];
                    data_next  = '0;
                    cnt_next   = '0;
                    state_next = rx_data[CMD_WR_BIT] ? WR_DATA : RD_REQ;
                end else begin
                    state_next = IDLE;
                end
            end
            WR_DATA: begin
                // A byte arriving on the expiry edge still counts as in time.
                if (rx_valid) begin
                    rx_take_s = 1'b1;
                    data_next = data_r | (DW'(rx_data) << {cnt_r, 3'b000});
                    if (cnt_r == LAST) begin
                        cnt_next   = '0;
                        state_next = WR_ISSUE;
                    end else begin
                        cnt_next = cnt_r + CNT_W'(1);
                    end
                end else if (expired_s) begin
                    timeout_s  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WR_DATA;
                end
            end
            WR_ISSUE: state_next = IDLE;
            RD_REQ:   state_next = RD_WAIT;
            RD_WAIT: begin
                if (reg_rd_valid) begin
                    data_next  = reg_rdata;
                    cnt_next   = '0;
                    state_next = TX;
                end else if (expired_s) begin
                    timeout_s  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RD_WAIT;
                end
            end
            TX: begin
                if (tx_ready) begin
                    if (cnt_r == LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_next = TX;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_byte_s   = 8'(data_next >> {cnt_next, 3'b000});
    assign timer_clr_s = (state_next != state_r) || rx_take_s;
    assign timer_en_s  = (state_r == WR_DATA) || (state_r == RD_WAIT);

    cmd_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (expired_s)
    );

    // State, data holding registers and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            data_r      <= '0;
            addr_r      <= '0;
            busy_r      <= 1'b0;
            reg_wr_r    <= 1'b0;
            reg_rd_r    <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            reg_wdata_r <= '0;
            reg_addr_r  <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next;
            cnt_r       <= cnt_next;
            data_r      <= data_next;
            addr_r      <= addr_next;
            busy_r      <= (state_next != IDLE);
            reg_wr_r    <= (state_next == WR_ISSUE);
            reg_rd_r    <= (state_next == RD_REQ);
            tx_valid_r  <= (state_next == TX);
            tx_data_r   <= (state_next == TX) ? tx_byte_s : 8'h00;
            reg_wdata_r <= (state_next == WR_ISSUE) ? data_next : '0;
            reg_addr_r  <= (state_next == IDLE) ? '0 : addr_next;
            err_r       <= timeout_s;
        end
    end

    assign busy        = busy_r;
    assign reg_wr      = reg_wr_r;
    assign reg_rd      = reg_rd_r;
    assign tx_valid    = tx_valid_r;
    assign tx_data     = tx_data_r;
    assign reg_wdata   = reg_wdata_r;
    assign reg_addr    = reg_addr_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_cmd_bridge.sv
// Randomised bench for cmd_bridge (ADDR_W=4, DATA_BYTES=2, TIMEOUT_CYC=10) with a cycle-timeline model.
module tb_cmd_bridge;

    localparam int AW = 4;
    localparam int NB = 2;
    localparam int TO = 10;
    localparam int DW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          reg_wr;
    logic          reg_rd;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata;
    logic          reg_rd_valid;
    logic          busy;
    logic          err_timeout;

    always #5 clk = ~clk;

    cmd_bridge #(.ADDR_W(AW), .DATA_BYTES(NB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rd_valid(reg_rd_valid),
        .busy(busy), .err_timeout(err_timeout)
    );

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    // expected outputs for the current cycle
    logic          exp_busy, exp_wr, exp_rd, exp_txv, exp_err;
    logic [7:0]    exp_txd;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;

    int            wr_cnt = 0;
    int            err_cnt = 0;
    logic [AW-1:0] last_wa;
    logic [DW-1:0] last_wd;
    logic [7:0]    tx_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (run) begin
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("reg_wr", 32'(reg_wr), 32'(exp_wr));
                chk("reg_rd", 32'(reg_rd), 32'(exp_rd));
                chk("tx_valid", 32'(tx_valid), 32'(exp_txv));
                chk("err_timeout", 32'(err_timeout), 32'(exp_err));
                if (exp_busy) chk("reg_addr", 32'(reg_addr), 32'(exp_addr));
                if (exp_wr)   chk("reg_wdata", 32'(reg_wdata), 32'(exp_wdata));
                if (exp_txv)  chk("tx_data", 32'(tx_data), 32'(exp_txd));
                if (reg_wr) begin
                    wr_cnt++;
                    last_wa = reg_addr;
                    last_wd = reg_wdata;
                end
                if (err_timeout) err_cnt++;
                if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            end
        end
    end

    task automatic clear_exp();
        exp_busy = 1'b0; exp_wr = 1'b0; exp_rd = 1'b0; exp_txv = 1'b0; exp_err = 1'b0;
        exp_txd = 8'h00; exp_addr = '0; exp_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        rx_data      = 8'($urandom);
        reg_rd_valid = 1'b0;
        reg_rdata    = DW'($urandom);
        tx_ready     = 1'($urandom);
        clear_exp();
    endtask

    task automatic hold(input logic [AW-1:0] a);
        exp_busy = 1'b1;
        exp_addr = a;
    endtask

    task automatic noise_rx();
        if ($urandom_range(0, 1) == 1) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
    endtask

    // Starts in an idle cycle, ends in the idle cycle after the transaction.
    task automatic do_write(input logic [7:0] cmd, input logic [DW-1:0] data, input int gapmax);
        logic [AW-1:0] a;
        int g;
        a = cmd[AW-1:0];
        rx_valid = 1'b1; rx_data = cmd;
        for (int i = 0; i < NB; i++) begin
            g = int'($urandom_range(0, gapmax));
            repeat (g) begin tick(); hold(a); end
            tick(); hold(a);
            rx_valid = 1'b1;
            rx_data  = 8'(data >> (8 * i));
        end
        tick(); hold(a); exp_wr = 1'b1; exp_wdata = data; noise_rx();
        tick();
    endtask

    // One data byte then silence; ends in the err_timeout cycle (already IDLE).
    task automatic do_write_to(input logic [7:0] cmd, input logic [7:0] b0);
        logic [AW-1:0] a;
        a = cmd[AW-1:0];
        rx_valid = 1'b1; rx_data = cmd;
        tick(); hold(a); rx_valid = 1'b1; rx_data = b0;
        repeat (TO) begin tick(); hold(a); end
        tick(); exp_err = 1'b1;
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [DW-1:0] rdata, input int lat,
                           input int stall0, input bit to_);
        logic [AW-1:0] a;
        int waited;
        bit acc;
        a = cmd[AW-1:0];
        rx_valid = 1'b1; rx_data = cmd;
        tick(); hold(a); exp_rd = 1'b1; noise_rx();
        if (to_) begin
            repeat (TO) begin tick(); hold(a); noise_rx(); end
            tick(); exp_err = 1'b1;
            return;
        end
        repeat (lat) begin tick(); hold(a); noise_rx(); end
        tick(); hold(a); reg_rd_valid = 1'b1; reg_rdata = rdata; noise_rx();
        for (int b = 0; b < NB; b++) begin
            waited = 0;
            acc = 1'b0;
            while (!acc) begin
                tick(); hold(a);
                exp_txv = 1'b1;
                exp_txd = 8'(rdata >> (8 * b));
                noise_rx();
                if ($urandom_range(0, 3) == 0) begin
                    reg_rd_valid = 1'b1;
                    reg_rdata = DW'($urandom);
                end
                if (b == 0 && stall0 > 0) tx_ready = (waited >= stall0);
                else tx_ready = 1'($urandom);
                acc = tx_ready;
                waited++;
            end
        end
        tick();
    endtask

    task automatic do_reset_mid();
        rx_valid = 1'b1; rx_data = 8'h85;
        tick(); hold(4'h5); rx_valid = 1'b1; rx_data = 8'h34;
        tick(); hold(4'h5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_addr", 32'(reg_addr), 32'd0);
        chk("async_rst_wr", 32'(reg_wr), 32'd0);
        chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
        clear_exp();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int w0;
        int e0;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        reg_rdata = '0; reg_rd_valid = 1'b0;
        clear_exp();
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_reg_wr", 32'(reg_wr), 32'd0);
        chk("reset_reg_rd", 32'(reg_rd), 32'd0);
        tick();
        rst_n = 1'b1;

        w0 = wr_cnt;
        do_write(8'h85, 16'h1234, 0);
        chk("pin_wr_cnt", 32'(wr_cnt), 32'(w0 + 1));
        chk("pin_wr_addr", 32'(last_wa), 32'h5);
        chk("pin_wr_data", 32'(last_wd), 32'h1234);

        tx_log.delete();
        do_read(8'h03, 16'hBEEF, 2, 5, 1'b0);
        chk("pin_tx_len", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            chk("pin_tx_b0", 32'(tx_log[0]), 32'hEF);
            chk("pin_tx_b1", 32'(tx_log[1]), 32'hBE);
        end

        do_write(8'hFA, 16'h5A5A, 1);
        chk("pin_addr_mask", 32'(last_wa), 32'hA);

        w0 = wr_cnt;
        e0 = err_cnt;
        tx_log.delete();
        do_write_to(8'h81, 8'h11);
        do_read(8'h02, 16'hC0DE, 0, 0, 1'b0);
        chk("pin_to_no_wr", 32'(wr_cnt), 32'(w0));
        chk("pin_to_err", 32'(err_cnt), 32'(e0 + 1));
        chk("pin_after_to_len", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            chk("pin_after_to_b0", 32'(tx_log[0]), 32'hDE);
            chk("pin_after_to_b1", 32'(tx_log[1]), 32'hC0);
        end

        do_reset_mid();
        do_write(8'h87, 16'h00FF, 0);
        chk("pin_fresh_addr", 32'(last_wa), 32'h7);
        chk("pin_fresh_data", 32'(last_wd), 32'h00FF);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0, 1: do_write({1'b1, 7'($urandom)}, DW'($urandom), 3);
                2, 3: do_read({1'b0, 7'($urandom)}, DW'($urandom), int'($urandom_range(0, 6)),
                              int'($urandom_range(0, 3)), 1'b0);
                4: begin
                    if ($urandom_range(0, 1) == 1) do_write_to({1'b1, 7'($urandom)}, 8'($urandom));
                    else do_read({1'b0, 7'($urandom)}, DW'($urandom), 0, 0, 1'b1);
                end
                default: tick();
            endcase
        end

        tick();
        tick();
        @(negedge clk);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
